// File: rtl/awgn_channel_adder.sv
// AWGN channel adder: scales Gaussian noise pairs by a programmable sigma and adds them to a
// valid/ready signal stream, saturating to the signed output range. Two-entry noise pair
// buffer feeds a two-stage stallable pipeline (multiply, then round/add/clamp).
module awgn_channel_adder #(
  parameter int unsigned DW         = 16,
  parameter int unsigned SIGMA_FRAC = 12,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    noise_x0,
  input  logic [DW-1:0]    noise_x1,
  input  logic             noise_valid,
  input  logic [15:0]      sigma,
  input  logic [DW-1:0]    sig_in,
  input  logic             sig_valid,
  output logic             sig_ready,
  output logic [DW-1:0]    y_out,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sat_flag,
  output logic [15:0]      sat_count,
  output logic [CNT_W-1:0] sample_count
);

  // Product of signed DW-bit noise and 17-bit zero-extended sigma.
  localparam int unsigned PW = DW + 17;
  // One guard bit so sig + r cannot overflow before the clamp.
  localparam int unsigned SW = PW + 1;

  localparam logic signed [PW-1:0] RoundC = PW'(2 ** (SIGMA_FRAC - 1));
  localparam logic signed [SW-1:0] MaxS   = SW'(2 ** (DW - 1) - 1);
  localparam logic signed [SW-1:0] MinS   = ~MaxS;

  // Noise pair buffer
  logic [DW-1:0] nb0_q, nb0_d;
  logic [DW-1:0] nb1_q, nb1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    cnt_post;
  logic [DW-1:0] n_sel;

  // Pipeline control
  logic en;
  logic hs;
  logic out_hs;

  // Stage 1
  logic                 s1_valid_q, s1_valid_d;
  logic [DW-1:0]        s1_sig_q, s1_sig_d;
  logic signed [PW-1:0] s1_p_q, s1_p_d;
  logic signed [PW-1:0] n_ext;
  logic signed [PW-1:0] g_ext;
  logic signed [PW-1:0] prod;

  // Stage 2
  logic signed [PW-1:0] p_rnd;
  logic signed [PW-1:0] r;
  logic signed [SW-1:0] s;
  logic                 y_valid_q, y_valid_d;
  logic [DW-1:0]        y_out_q, y_out_d;
  logic                 sat_q, sat_d;

  // Counters
  logic [15:0]      sat_cnt_q, sat_cnt_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

  // Pipeline enable and input acceptance; no bypass, so an empty buffer blocks input.
  always_comb begin
    en        = !y_valid_q || y_ready;
    sig_ready = en && (cnt_q != 2'd0) && !reset;
    hs        = sig_valid && sig_ready;
    out_hs    = y_valid_q && y_ready;
  end

  // Noise buffer: consume x0 then x1, reload only once the buffer would be empty.
  always_comb begin
    n_sel    = (cnt_q == 2'd2) ? nb0_q : nb1_q;
    cnt_post = hs ? (cnt_q - 2'd1) : cnt_q;
    nb0_d    = nb0_q;
    nb1_d    = nb1_q;
    cnt_d    = cnt_post;
    // Pairs arriving while entries remain are dropped; the samples are i.i.d.
    if (noise_valid && (cnt_post == 2'd0)) begin
      nb0_d = noise_x0;
      nb1_d = noise_x1;
      cnt_d = 2'd2;
    end
  end

  // Stage 1 next state: capture sample and noise*sigma on handshake, bubble otherwise.
  always_comb begin
    n_ext      = {{(PW - DW){n_sel[DW-1]}}, n_sel};
    g_ext      = {{(PW - 16){1'b0}}, sigma};
    prod       = n_ext * g_ext;
    s1_valid_d = s1_valid_q;
    s1_sig_d   = s1_sig_q;
    s1_p_d     = s1_p_q;
    if (en) begin
      s1_valid_d = hs;
      if (hs) begin
        s1_sig_d = sig_in;
        s1_p_d   = prod;
      end
    end
  end

  // Stage 2 next state: round half up, add at full width, clamp to the output range.
  always_comb begin
    p_rnd     = s1_p_q + RoundC;
    r         = p_rnd >>> SIGMA_FRAC;
    s         = {{(SW - DW){s1_sig_q[DW-1]}}, s1_sig_q} + {r[PW-1], r};
    y_valid_d = y_valid_q;
    y_out_d   = y_out_q;
    sat_d     = sat_q;
    if (en) begin
      y_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s > MaxS) begin
          y_out_d = MaxS[DW-1:0];
          sat_d   = 1'b1;
        end else if (s < MinS) begin
          y_out_d = MinS[DW-1:0];
          sat_d   = 1'b1;
        end else begin
          y_out_d = s[DW-1:0];
          sat_d   = 1'b0;
        end
      end
    end
  end

  // Output handshake counters: sample count wraps, saturation count sticks at all ones.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    sat_cnt_d    = sat_cnt_q;
    if (out_hs) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (sat_q && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_d = sat_cnt_q + 16'd1;
      end
    end
  end

  // State registers with synchronous reset; reset discards buffered noise and in-flight data.
  always_ff @(posedge clk) begin
    if (reset) begin
      nb0_q        <= '0;
      nb1_q        <= '0;
      cnt_q        <= 2'd0;
      s1_valid_q   <= 1'b0;
      s1_sig_q     <= '0;
      s1_p_q       <= '0;
      y_valid_q    <= 1'b0;
      y_out_q      <= '0;
      sat_q        <= 1'b0;
      sat_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      nb0_q        <= nb0_d;
      nb1_q        <= nb1_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_sig_q     <= s1_sig_d;
      s1_p_q       <= s1_p_d;
      y_valid_q    <= y_valid_d;
      y_out_q      <= y_out_d;
      sat_q        <= sat_d;
      sat_cnt_q    <= sat_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Registered outputs
  always_comb begin
    y_out        = y_out_q;
    y_valid      = y_valid_q;
    sat_flag     = sat_q;
    sat_count    = sat_cnt_q;
    sample_count = sample_cnt_q;
  end

endmodule

// File: tb/tb_awgn_channel_adder.sv
// Bench for awgn_channel_adder: table of noise-pair/sample vectors with hand-derived results,
// a scoreboard queue checked by an output monitor, and hand-written corner sequences.
module tb_awgn_channel_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] noise_x0, noise_x1;
  logic        noise_valid;
  logic [15:0] sigma;
  logic [15:0] sig_in;
  logic        sig_valid;
  logic        sig_ready;
  logic [15:0] y_out;
  logic        y_valid;
  logic        y_ready;
  logic        sat_flag;
  logic [15:0] sat_count;
  logic [31:0] sample_count;

  awgn_channel_adder #(
    .DW(16),
    .SIGMA_FRAC(12),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .noise_x0(noise_x0),
    .noise_x1(noise_x1),
    .noise_valid(noise_valid),
    .sigma(sigma),
    .sig_in(sig_in),
    .sig_valid(sig_valid),
    .sig_ready(sig_ready),
    .y_out(y_out),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .sat_flag(sat_flag),
    .sat_count(sat_count),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sigma0;
    logic [15:0] sigma1;
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] y0;
    logic [15:0] y1;
    logic        f0;
    logic        f1;
  } vec_t;

  vec_t        vecs [8];
  vec_t        v;
  int          n_pass = 0;
  int          n_fail = 0;
  int          mdl_cnt = 0;
  int          sat_exp = 0;
  logic [15:0] q_y[$];
  logic        q_f[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    logic [15:0] ey;
    logic        ef;
    #2;
    if (!reset && y_valid && y_ready) begin
      if (q_y.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got y_out %0h with empty scoreboard", y_out);
      end else begin
        ey = q_y.pop_front();
        ef = q_f.pop_front();
        check("y_out", {16'h0, y_out}, {16'h0, ey});
        check("sat_flag", {31'h0, sat_flag}, {31'h0, ef});
        mdl_cnt++;
      end
    end
  end

  // Drive one sample until accepted; returns at the negedge after the handshake edge.
  task automatic accept(input logic [15:0] s, input logic [15:0] ey, input logic ef);
    bit done;
    done      = 1'b0;
    sig_in    = s;
    sig_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (sig_ready) begin
        q_y.push_back(ey);
        q_f.push_back(ef);
        done = 1'b1;
      end
      @(negedge clk);
    end
    sig_valid = 1'b0;
    if (!done) begin
      n_fail++;
      $display("FAIL accept_timeout: sample %0h not accepted, got none expected 1", s);
    end
  endtask

  task automatic pulse_pair(input logic [15:0] a, input logic [15:0] b);
    noise_x0    = a;
    noise_x1    = b;
    noise_valid = 1'b1;
    @(negedge clk);
    noise_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          hits;
    int          acc;
    int          yv;
    logic [15:0] y_hold;

    // sigma0 sigma1 x0 x1 s0 s1 y0 y1 f0 f1
    vecs[0] = '{16'h1000, 16'h1000, 16'h0800, 16'hF800, 16'h0400, 16'h0400,
                16'h0C00, 16'hFC00, 1'b0, 1'b0};
    vecs[1] = '{16'h1000, 16'h1000, 16'h4000, 16'hC000, 16'h7000, 16'h9000,
                16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[2] = '{16'h0800, 16'h0800, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000,
                16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h1234, 16'h8000,
                16'h1234, 16'h8000, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h0010, 16'hFFF0, 16'h0100, 16'hFF00,
                16'h0200, 16'hFE00, 1'b0, 1'b0};
    vecs[5] = '{16'h1800, 16'h1800, 16'h0003, 16'hFFFD, 16'h7FFF, 16'h8000,
                16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[6] = '{16'h0800, 16'h0800, 16'h0003, 16'hFFFD, 16'h0010, 16'h0010,
                16'h0012, 16'h000F, 1'b0, 1'b0};
    vecs[7] = '{16'h1000, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000,
                16'h0100, 16'h0000, 1'b0, 1'b0};

    reset       = 1'b1;
    noise_x0    = '0;
    noise_x1    = '0;
    noise_valid = 1'b0;
    sigma       = '0;
    sig_in      = '0;
    sig_valid   = 1'b0;
    y_ready     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_y_out", {16'h0, y_out}, 32'h0);
    check("rst_y_valid", {31'h0, y_valid}, 32'h0);
    check("rst_sat_flag", {31'h0, sat_flag}, 32'h0);
    check("rst_sat_count", {16'h0, sat_count}, 32'h0);
    check("rst_sample_count", sample_count, 32'h0);
    check("rst_sig_ready", {31'h0, sig_ready}, 32'h0);
    reset = 1'b0;

    // No noise ever delivered: input must never be accepted.
    hits      = 0;
    sig_valid = 1'b1;
    repeat (10) begin
      #1;
      if (sig_ready) hits++;
      @(negedge clk);
    end
    sig_valid = 1'b0;
    check("no_noise_no_ready", hits, 0);

    // Table: one pair per vector, two samples, x0 consumed first then x1.
    for (int i = 0; i < 8; i++) begin
      v     = vecs[i];
      sigma = v.sigma0;
      pulse_pair(v.x0, v.x1);
      accept(v.s0, v.y0, v.f0);
      check("lat_before", {31'h0, y_valid}, 32'h0);
      sigma = v.sigma1;
      accept(v.s1, v.y1, v.f1);
      check("lat_after", {31'h0, y_valid}, 32'h1);
      check("ready_drop", {31'h0, sig_ready}, 32'h0);
      repeat (4) @(negedge clk);
      sat_exp += int'(v.f0) + int'(v.f1);
      check("tbl_sample_count", sample_count, 32'(2 * (i + 1)));
      check("tbl_sat_count", {16'h0, sat_count}, 32'(sat_exp));
    end

    // Second pair offered while the buffer is full must be dropped.
    sigma = 16'h1000;
    pulse_pair(16'h0100, 16'h0200);
    pulse_pair(16'h0300, 16'h0400);
    accept(16'h0000, 16'h0100, 1'b0);
    accept(16'h0000, 16'h0200, 1'b0);
    hits      = 0;
    sig_valid = 1'b1;
    repeat (8) begin
      #1;
      if (sig_ready) hits++;
      @(negedge clk);
    end
    sig_valid = 1'b0;
    check("empty_after_two", hits, 0);
    repeat (3) @(negedge clk);
    check("drop_sample_count", sample_count, 32'(mdl_cnt));

    // Backpressure: y_ready low, continuous valid and noise; exactly two accepts.
    y_ready     = 1'b0;
    noise_x0    = 16'h0000;
    noise_x1    = 16'h0000;
    noise_valid = 1'b1;
    @(negedge clk);
    acc       = 0;
    y_hold    = '0;
    sig_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sig_in = 16'h0020 + 16'(c);
      #1;
      if (sig_ready) begin
        q_y.push_back(sig_in);
        q_f.push_back(1'b0);
        acc++;
      end
      if (c == 2) y_hold = y_out;
      @(negedge clk);
    end
    check("bp_accepts", acc, 2);
    check("bp_y_valid", {31'h0, y_valid}, 32'h1);
    check("bp_y_stable", {16'h0, y_out}, {16'h0, y_hold});
    check("bp_sig_ready", {31'h0, sig_ready}, 32'h0);
    sig_valid   = 1'b0;
    noise_valid = 1'b0;
    y_ready     = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_drained", q_y.size(), 0);
    check("bp_sample_count", sample_count, 32'(mdl_cnt));

    // Reset with both stages valid and one noise entry left.
    sigma = 16'h1000;
    accept(16'h0055, 16'h0055, 1'b0);
    repeat (3) @(negedge clk);
    y_ready     = 1'b0;
    noise_valid = 1'b1;
    accept(16'h0066, 16'h0066, 1'b0);
    noise_valid = 1'b0;
    accept(16'h0077, 16'h0077, 1'b0);
    check("pre_rst_y_valid", {31'h0, y_valid}, 32'h1);
    reset = 1'b1;
    q_y.delete();
    q_f.delete();
    @(negedge clk);
    mdl_cnt = 0;
    check("mid_rst_y_valid", {31'h0, y_valid}, 32'h0);
    check("mid_rst_sig_ready", {31'h0, sig_ready}, 32'h0);
    check("mid_rst_sample_count", sample_count, 32'h0);
    check("mid_rst_sat_count", {16'h0, sat_count}, 32'h0);
    check("mid_rst_y_out", {16'h0, y_out}, 32'h0);
    reset     = 1'b0;
    y_ready   = 1'b1;
    sig_valid = 1'b1;
    hits      = 0;
    yv        = 0;
    repeat (6) begin
      #1;
      if (sig_ready) hits++;
      if (y_valid) yv++;
      @(negedge clk);
    end
    sig_valid = 1'b0;
    check("post_rst_no_ready", hits, 0);
    check("post_rst_no_output", yv, 0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
